regfile_dump_reader: RTL and testbench

//  Debug reader on the register-file read side. On a start pulse it walks register

---
 rtl/regdump_pkg.sv | 24 ++
 rtl/word_byte_serializer.sv | 44 ++++
 rtl/regfile_dump_reader.sv | 121 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regdump_pkg                                                       |
// | Shared types and helpers for the register-file dump reader.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package regdump_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_byte_serializer                                              |
// | Captures one word and presents it a byte at a time, LSB first.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module word_byte_serializer
  import regdump_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [DW-1:0] word,
  output logic [7:0]    byte_out,
  output logic          last_byte
);

  localparam int BYTES = bytes_per_word(DW);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DW-1:0] r_shreg;
  logic [CW-1:0] r_byte_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else if (load) begin
      r_shreg    <= word;
      r_byte_cnt <= '0;
    end else if (shift) begin
      r_shreg    <= r_shreg >> 8;
      r_byte_cnt <= r_byte_cnt + CW'(1);
    end
  end

  assign byte_out  = r_shreg[7:0];
  assign last_byte = (r_byte_cnt == CW'(BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_dump_reader                                               |
// | Walks register addresses FIRST..LAST and streams them as bytes.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int         DW    = 32,
  parameter int         AW    = 5,
  parameter int         FIRST = 0,
  parameter int         LAST  = 31,
  parameter logic [7:0] SYNC  = C_SYNC_BYTE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] c_first = AW'(FIRST);
  localparam logic [AW-1:0] c_last  = AW'(LAST);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic          w_shift;
  logic [7:0]    w_byte;
  logic          w_last_byte;

  // tx_valid is only ever high in SYNC/SEND, so tx_ready alone marks the handshake there.
  assign w_load  = (r_state == S_LOAD);
  assign w_shift = (r_state == S_SEND) && tx_ready && !w_last_byte;

  word_byte_serializer #(
    .DW (DW)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (w_load),
    .shift     (w_shift),
    .word      (rf_data),
    .byte_out  (w_byte),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= c_first;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SYNC;
            r_idx      <= c_first;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_SYNC: begin
          if (tx_ready) begin
            r_state    <= S_LOAD;
            r_tx_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state    <= S_SEND;
          r_tx_valid <= 1'b1;
        end
        S_SEND: begin
          if (tx_ready && w_last_byte) begin
            r_tx_valid <= 1'b0;
            // Terminating on equality keeps idx from wrapping when LAST is the top address.
            if (r_idx == c_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign rf_addr  = r_idx;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tx_data  = (r_state == S_SYNC) ? SYNC :
                    (r_state == S_SEND) ? w_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_dump_reader                                            |
// | Directed and randomized frame checks against a byte-queue model.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_regfile_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic        tx_ready = 1'b0, tx_ready1 = 1'b0;
  logic [4:0]  rf_addr0, rf_addr1;
  logic [31:0] rf_data0, rf_data1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, busy0, busy1, done0, done1;
  logic [31:0] rf [32];

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  assign rf_data0 = rf[rf_addr0];
  assign rf_data1 = rf[rf_addr1];

  always #5 clock = ~clock;

  regfile_dump_reader dut (
    .clock (clock), .reset (reset), .start (start),
    .rf_addr (rf_addr0), .rf_data (rf_data0),
    .tx_data (tx_data0), .tx_valid (tx_valid0), .tx_ready (tx_ready),
    .busy (busy0), .done (done0)
  );

  regfile_dump_reader #(.FIRST(3), .LAST(3)) dut1 (
    .clock (clock), .reset (reset), .start (start1),
    .rf_addr (rf_addr1), .rf_data (rf_data1),
    .tx_data (tx_data1), .tx_valid (tx_valid1), .tx_ready (tx_ready1),
    .busy (busy1), .done (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream: sync byte, then each word little-endian in ascending address order.
  task automatic build_exp(input int first, input int last);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = first; k <= last; k++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(rf[k][8*b +: 8]);
  endtask

  task automatic compare_frame(input string tag);
    logic [7:0] g;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
    end
  endtask

  // Collects accepted bytes until done; cycle 1 is the cycle after the start pulse.
  task automatic run_frame(input bit sel, input int pct, input int maxc, input bit inj,
                           input bit do_start, output int done_cyc);
    logic v, dn, r, pv, pr;
    logic [7:0] d, pd;
    got.delete();
    done_cyc = -1;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    if (do_start) begin
      @(negedge clock);
      if (sel) start1 = 1'b1; else start = 1'b1;
    end
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clock);
      start = 1'b0; start1 = 1'b0;
      v  = sel ? tx_valid1 : tx_valid0;
      d  = sel ? tx_data1  : tx_data0;
      dn = sel ? done1     : done0;
      if (pv && !pr)
        chk("stall_hold", {23'd0, v, d}, {23'd0, 1'b1, pd});
      r = ($urandom_range(0, 99) < pct);
      if (sel) tx_ready1 = r; else tx_ready = r;
      if (v && r) got.push_back(d);
      if (inj && c == 20) start = 1'b1;
      if (dn) begin
        done_cyc = c;
        if (inj) start = 1'b1;
        break;
      end
      pv = v; pr = r; pd = d;
    end
  endtask

  initial begin
    int  dc;
    bit  flag;
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + k;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_valid", {31'd0, tx_valid0}, 32'd0);
    chk("rst_data",  {24'd0, tx_data0},  32'd0);
    chk("rst_busy",  {31'd0, busy0},     32'd0);
    chk("rst_done",  {31'd0, done0},     32'd0);
    chk("rst_addr",  {27'd0, rf_addr0},  32'd0);
    chk("rst_addr1", {27'd0, rf_addr1},  32'd3);
    reset = 1'b0;
    @(negedge clock);

    // Full frame, ready held high
    build_exp(0, 31);
    run_frame(1'b0, 100, 400, 1'b0, 1'b1, dc);
    chk("full_done_cycle", 32'(dc), 32'd162);
    compare_frame("full");

    // Same frame under 30% ready duty
    run_frame(1'b0, 30, 3000, 1'b0, 1'b1, dc);
    chk("duty_done_seen", {31'd0, dc > 0}, 32'd1);
    compare_frame("duty");

    // Single-register instance
    rf[3] = 32'hDEAD_BEEF;
    build_exp(3, 3);
    run_frame(1'b1, 100, 100, 1'b0, 1'b1, dc);
    chk("single_done_cycle", 32'(dc), 32'd7);
    compare_frame("single");
    rf[3] = 32'h1000_0003;

    // start during SEND and in the DONE cycle must not restart
    build_exp(0, 31);
    run_frame(1'b0, 100, 400, 1'b1, 1'b1, dc);
    chk("inj_done_cycle", 32'(dc), 32'd162);
    compare_frame("inj");
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (tx_valid0 || busy0 || done0) flag = 1'b1;
    end
    chk("inj_no_restart", {31'd0, flag}, 32'd0);

    // Stall in SYNC
    @(negedge clock);
    tx_ready = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("sync_hold", {18'd0, tx_valid0, tx_data0, rf_addr0}, {18'd0, 1'b1, 8'hA5, 5'd0});
      @(negedge clock);
    end
    run_frame(1'b0, 60, 3000, 1'b0, 1'b0, dc);
    chk("sync_done_seen", {31'd0, dc > 0}, 32'd1);
    compare_frame("sync");

    // Reset while sending register 17
    @(negedge clock);
    tx_ready = 1'b1;
    start = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 400 && !flag; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (tx_valid0 && rf_addr0 == 5'd17) flag = 1'b1;
    end
    chk("rst_mid_found", {31'd0, flag}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, tx_valid0}, 32'd0);
    chk("rst_mid_busy",  {31'd0, busy0},     32'd0);
    @(negedge clock);
    reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done0 || tx_valid0) flag = 1'b1;
    end
    chk("rst_mid_quiet", {31'd0, flag}, 32'd0);
    run_frame(1'b0, 100, 400, 1'b0, 1'b1, dc);
    chk("rst_fresh_done", 32'(dc), 32'd162);
    compare_frame("rst_fresh");

    // Random register contents, random ready
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    build_exp(0, 31);
    run_frame(1'b0, 45, 3000, 1'b0, 1'b1, dc);
    chk("rand_done_seen", {31'd0, dc > 0}, 32'd1);
    compare_frame("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
